// File: rtl/varredura_pkg.sv
// rtl/varredura_pkg.sv - shared constants and state encoding for the LED matrix scan driver
package varredura_pkg;

    localparam int NUM_COLUNAS = 5;
    localparam int NUM_LINHAS  = 7;

    localparam logic [NUM_COLUNAS-1:0] APAGADO_COL = 5'b11111;
    localparam logic [NUM_LINHAS-1:0]  APAGADO_LIN = 7'b1111111;

    typedef enum logic [1:0] {
        DESLIGADO = 2'd0,
        BLANK     = 2'd1,
        ATIVO     = 2'd2
    } estado_t;

endpackage

// File: rtl/contador_varredura.sv
// rtl/contador_varredura.sv - slot counter, column index, scan state and frame-boundary strobe
module contador_varredura
    import varredura_pkg::*;
#(
    parameter int DIV_VARREDURA = 50000,
    parameter int BLANK_CICLOS  = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ligado,
    output logic       ativo,
    output logic [2:0] idx,
    output logic       fim_quadro
);

    localparam int CNT_W = $clog2(DIV_VARREDURA);
    localparam logic [CNT_W-1:0] CNT_ULTIMO    = CNT_W'(DIV_VARREDURA - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK_FIM = CNT_W'(BLANK_CICLOS - 1);
    localparam logic [2:0]       IDX_ULTIMO    = 3'(NUM_COLUNAS - 1);

    estado_t          estado, estado_prox;
    logic [CNT_W-1:0] cnt, cnt_prox;
    logic [2:0]       idx_prox;

    always_ff @(posedge clock) begin
        if (reset) begin
            estado <= ligado ? BLANK : DESLIGADO;
            cnt    <= '0;
            idx    <= '0;
        end else begin
            estado <= estado_prox;
            cnt    <= cnt_prox;
            idx    <= idx_prox;
        end
    end

    always_comb begin
        estado_prox = estado;
        cnt_prox    = cnt;
        idx_prox    = idx;
        if (!ligado) begin
            estado_prox = DESLIGADO;
            cnt_prox    = '0;
            idx_prox    = '0;
        end else begin
            case (estado)
                DESLIGADO: begin
                    estado_prox = BLANK;
                    cnt_prox    = '0;
                    idx_prox    = '0;
                end
                BLANK: begin
                    cnt_prox = cnt + 1'b1;
                    if (cnt == CNT_BLANK_FIM)
                        estado_prox = ATIVO;
                end
                ATIVO: begin
                    if (cnt == CNT_ULTIMO) begin
                        cnt_prox    = '0;
                        estado_prox = BLANK;
                        idx_prox    = (idx == IDX_ULTIMO) ? 3'd0 : idx + 3'd1;
                    end else begin
                        cnt_prox = cnt + 1'b1;
                    end
                end
                default: estado_prox = DESLIGADO;
            endcase
        end
    end

    // The counter only reaches its last value while ATIVO, so this marks the frame edge exactly once.
    assign ativo      = (estado == ATIVO);
    assign fim_quadro = ativo && (cnt == CNT_ULTIMO) && (idx == IDX_ULTIMO);

endmodule

// File: rtl/varredura_matriz.sv
// rtl/varredura_matriz.sv - multiplexed 5x7 LED matrix scan driver with frame shadow and blink
module varredura_matriz
    import varredura_pkg::*;
#(
    parameter int DIV_VARREDURA = 50000,
    parameter int BLANK_CICLOS  = 16,
    parameter int PISCA_QUADROS = 50
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ligado,
    input  logic       pisca_habilita,
    input  logic [6:0] coluna1_entrada,
    input  logic [6:0] coluna2_entrada,
    input  logic [6:0] coluna3_entrada,
    input  logic [6:0] coluna4_entrada,
    input  logic [6:0] coluna5_entrada,
    output logic [4:0] sel_coluna,
    output logic [6:0] linhas,
    output logic       fim_quadro
);

    localparam int QW = $clog2(PISCA_QUADROS + 1);
    localparam logic [QW-1:0] Q_ULTIMO = QW'(PISCA_QUADROS - 1);

    logic                  ativo;
    logic [2:0]            idx;
    logic                  fim;
    logic [NUM_LINHAS-1:0] sombra [NUM_COLUNAS];
    logic                  fase_visivel;
    logic [QW-1:0]         quadros;
    logic                  pisca_q;

    contador_varredura #(
        .DIV_VARREDURA (DIV_VARREDURA),
        .BLANK_CICLOS  (BLANK_CICLOS)
    ) u_contador (
        .clock      (clock),
        .reset      (reset),
        .ligado     (ligado),
        .ativo      (ativo),
        .idx        (idx),
        .fim_quadro (fim)
    );

    always_ff @(posedge clock) begin
        if (reset || !ligado) begin
            for (int i = 0; i < NUM_COLUNAS; i++)
                sombra[i] <= APAGADO_LIN;
            fase_visivel <= 1'b1;
            quadros      <= '0;
        end else if (fim) begin
            sombra[0] <= coluna1_entrada;
            sombra[1] <= coluna2_entrada;
            sombra[2] <= coluna3_entrada;
            sombra[3] <= coluna4_entrada;
            sombra[4] <= coluna5_entrada;
            if (quadros == Q_ULTIMO) begin
                quadros      <= '0;
                fase_visivel <= ~fase_visivel;
            end else begin
                quadros <= quadros + 1'b1;
            end
        end
    end

    // Blink enable is registered so no input reaches the pins combinationally.
    always_ff @(posedge clock) begin
        if (reset)
            pisca_q <= 1'b0;
        else
            pisca_q <= pisca_habilita;
    end

    always_comb begin
        sel_coluna = APAGADO_COL;
        linhas     = APAGADO_LIN;
        if (ativo) begin
            sel_coluna = ~(5'b00001 << idx);
            if (fase_visivel || !pisca_q)
                linhas = sombra[idx];
        end
    end

    assign fim_quadro = fim;

endmodule

// File: tb/tb_varredura_matriz.sv
// tb/tb_varredura_matriz.sv - self-checking bench for varredura_matriz against a frame-level model
module tb_varredura_matriz;

    localparam int DIV    = 8;
    localparam int BLANK  = 2;
    localparam int PISCA  = 2;
    localparam int QUADRO = 5 * DIV;

    logic       clock = 1'b0;
    logic       reset;
    logic       ligado;
    logic       pisca_habilita;
    logic [6:0] cols [5];
    logic [4:0] sel_coluna;
    logic [6:0] linhas;
    logic       fim_quadro;

    int checks = 0;
    int errors = 0;

    bit         m_on;
    int         m_t;
    int         m_nb;
    logic [6:0] m_sh [5];
    logic       m_pq;

    always #5 clock = ~clock;

    varredura_matriz #(
        .DIV_VARREDURA (DIV),
        .BLANK_CICLOS  (BLANK),
        .PISCA_QUADROS (PISCA)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .ligado          (ligado),
        .pisca_habilita  (pisca_habilita),
        .coluna1_entrada (cols[0]),
        .coluna2_entrada (cols[1]),
        .coluna3_entrada (cols[2]),
        .coluna4_entrada (cols[3]),
        .coluna5_entrada (cols[4]),
        .sel_coluna      (sel_coluna),
        .linhas          (linhas),
        .fim_quadro      (fim_quadro)
    );

    task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s t=%0d observed=%b expected=%b", tag, m_t, obs, exp);
        end
    endtask

    task automatic limpa_modelo();
        for (int i = 0; i < 5; i++) m_sh[i] = 7'h7f;
        m_nb = 0;
    endtask

    task automatic modelo_borda();
        if (reset) begin
            limpa_modelo();
            m_pq = 1'b0;
            m_on = ligado;
            m_t  = 0;
        end else begin
            m_pq = pisca_habilita;
            if (!ligado) begin
                limpa_modelo();
                m_on = 1'b0;
                m_t  = 0;
            end else if (!m_on) begin
                m_on = 1'b1;
                m_t  = 0;
            end else begin
                if (m_t % QUADRO == QUADRO - 1) begin
                    for (int i = 0; i < 5; i++) m_sh[i] = cols[i];
                    m_nb++;
                end
                m_t++;
            end
        end
    endtask

    task automatic passo();
        int         col;
        int         fatia;
        bit         act;
        bit         visivel;
        logic [4:0] e_sel;
        logic [6:0] e_lin;
        @(negedge clock);
        col     = (m_t % QUADRO) / DIV;
        fatia   = m_t % DIV;
        act     = m_on && (fatia >= BLANK);
        visivel = ((m_nb / PISCA) % 2) == 0;
        e_sel   = act ? ~(5'b00001 << col) : 5'b11111;
        e_lin   = (act && (visivel || !m_pq)) ? m_sh[col] : 7'h7f;
        chk("sel_coluna", {2'b00, sel_coluna}, {2'b00, e_sel});
        chk("linhas", linhas, e_lin);
        chk("fim_quadro", {6'd0, fim_quadro}, {6'd0, m_on && (m_t % QUADRO == QUADRO - 1)});
        modelo_borda();
        @(posedge clock);
        #1;
    endtask

    task automatic passos(input int n);
        for (int i = 0; i < n; i++) passo();
    endtask

    initial begin
        bit achou;
        reset          = 1'b1;
        ligado         = 1'b1;
        pisca_habilita = 1'b0;
        cols[0] = 7'b1111110;
        cols[1] = 7'b1111111;
        cols[2] = 7'b0111111;
        cols[3] = 7'b1111111;
        cols[4] = 7'b1111111;
        @(posedge clock);
        #1;
        m_on = 1'b1;
        m_t  = 0;
        m_pq = 1'b0;
        limpa_modelo();

        // reset held, then release: dark frame 0, pattern in frame 1
        passos(3);
        reset = 1'b0;
        passos(50);
        // input change mid-frame must wait for the boundary
        cols[0] = 7'b1111101;
        passos(60);

        // blink with a static pattern
        pisca_habilita = 1'b1;
        passos(220);
        pisca_habilita = 1'b0;
        passos(20);

        // disable mid-scan then re-enable
        ligado = 1'b0;
        passos(15);
        ligado = 1'b1;
        passos(100);

        // one-cycle reset during a column 4 active slot
        achou = 1'b0;
        for (int i = 0; i < 200 && !achou; i++) begin
            if (m_on && ((m_t % QUADRO) / DIV == 3) && (m_t % DIV >= BLANK))
                achou = 1'b1;
            else
                passo();
        end
        checks++;
        assert (achou) else begin
            errors++;
            $error("FAIL col4_wait observed=timeout expected=column4_active");
        end
        reset = 1'b1;
        passo();
        reset = 1'b0;
        passos(90);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(15) == 0) cols[$urandom_range(4)] = 7'($urandom);
            if ($urandom_range(99) == 0) pisca_habilita = ~pisca_habilita;
            ligado = ($urandom_range(249) != 0);
            reset  = ($urandom_range(599) == 0);
            passo();
        end
        reset  = 1'b0;
        ligado = 1'b1;
        passos(10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/varredura_matriz.md
Name: varredura_matriz

Overview:
Multiplexed scan driver for the physical 5x7 LED matrix. It is the consuming end of the five 7-bit column buses (active-low pixels, 0 = lit) that the game controller produces. It latches a whole frame atomically, scans one column at a time with a dark blanking gap between columns to prevent ghosting, and can blink the whole display. It sits between the game controller and the board pins.

Parameters:
DIV_VARREDURA, 50000, clock cycles per column slot (blank plus active); must be greater than BLANK_CICLOS.
BLANK_CICLOS, 16, dark cycles at the start of each slot; must be at least 1.
PISCA_QUADROS, 50, frames per blink half-period; must be at least 1.

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
ligado  in  1  display enable; 0 forces the display dark and clears the frame
pisca_habilita  in  1  1 = blink the whole display
coluna1_entrada  in  7  column 1 pixels, bit0 = row 1, active-low
coluna2_entrada  in  7  column 2 pixels
coluna3_entrada  in  7  column 3 pixels
coluna4_entrada  in  7  column 4 pixels
coluna5_entrada  in  7  column 5 pixels
sel_coluna  out  5  column enable, active-low one-hot; bit0 = column 1
linhas  out  7  row drive, active-low
fim_quadro  out  1  one-cycle pulse during the last cycle of the column 5 slot

Behaviour:
- Single clock domain. Reset is synchronous and active-high.
- Outputs are a pure decode of registers. There is no combinational path from any input to any output.
- Reset values:
  - sel_coluna = 5'b11111, linhas = 7'b1111111, fim_quadro = 0.
  - Shadow frame is all ones.
  - Column index = 0, slot counter = 0.
  - Blink phase = visible (1), frame counter = 0.
  - State = BLANK if ligado = 1, otherwise DESLIGADO.
- Slot counter width is $clog2(DIV_VARREDURA). It counts 0..DIV_VARREDURA-1 and then wraps.
- States:
  - DESLIGADO: outputs dark, all counters held at 0, shadow held at all ones.
    - ligado = 1 moves to BLANK next cycle, with index 0 and counter 0.
  - BLANK: counter 0..BLANK_CICLOS-1.
    - sel_coluna = 5'b11111, linhas = 7'b1111111.
    - Moves to ATIVO when counter reaches BLANK_CICLOS-1.
  - ATIVO: counter BLANK_CICLOS..DIV_VARREDURA-1.
    - sel_coluna[idx] = 0, all other bits 1.
    - linhas = shadow[idx] when (visible phase OR pisca_habilita = 0), otherwise 7'b1111111.
    - When counter reaches DIV_VARREDURA-1: counter returns to 0, idx advances (4 wraps to 0), state returns to BLANK.
- ligado = 0 in any state: DESLIGADO on the next edge. This clears the shadow, the counters and the blink phase (phase set back to visible).
- Frame boundary: counter = DIV_VARREDURA-1 AND idx = 4.
  - fim_quadro = 1 for exactly that cycle.
  - On that edge the shadow loads all five coluna*_entrada.
  - Input changes at any other time are ignored until the next boundary.
- Blink: the frame counter increments at each frame boundary.
  - When it reaches PISCA_QUADROS-1 at a boundary, it returns to 0 and the phase toggles.
  - The phase keeps running while pisca_habilita = 0; only the display is unaffected.
- A full frame takes 5*DIV_VARREDURA cycles. The first loaded frame appears from the second frame after enable; frame 0 is dark.
- Reset asserted mid-scan has priority over ligado and returns everything to the reset values on the next edge.

Decomposition:
- Package varredura_pkg holds:
  - NUM_COLUNAS = 5, NUM_LINHAS = 7
  - APAGADO_COL = 5'b11111, APAGADO_LIN = 7'b1111111
  - State encoding: DESLIGADO, BLANK, ATIVO
- One natural sub-module, contador_varredura: the slot counter plus column index plus frame-boundary strobe. The top level keeps the shadow, the blink logic and the output decode.

Test Plan:
All scenarios use DIV_VARREDURA = 8, BLANK_CICLOS = 2, PISCA_QUADROS = 2.
1. Hold reset, then release with ligado = 1 -> during reset: sel_coluna = 5'b11111, linhas = 7'b1111111, fim_quadro = 0. After release: frame 0 is dark and fim_quadro pulses only at cycle 39.
2. coluna1_entrada = 7'b1111110, coluna3_entrada = 7'b0111111, others all ones -> cycles 42-47: sel_coluna = 5'b11110, linhas = 7'b1111110. Cycles 58-63: sel_coluna = 5'b11011, linhas = 7'b0111111. Cycles 40-41: dark.
3. Change coluna1_entrada to 7'b1111101 at cycle 50 -> linhas remains 7'b1111110 during the column 1 slot until the boundary at cycle 79; 7'b1111101 appears at cycles 82-87.
4. pisca_habilita = 1 with a static pattern -> phase toggles at the boundaries at cycles 79, 159, and so on. Frames 2-3 show linhas = 7'b1111111 in all ATIVO cycles; frames 4-5 show the pattern again.
5. Drop ligado at cycle 45, then raise it at cycle 60 -> from cycle 46 all outputs are dark. After re-enable, scanning restarts at column 1 BLANK and the first frame is dark because the shadow was cleared.
6. Assert reset for one cycle during a column 4 ATIVO slot -> the next cycle equals the reset values (idx 0, BLANK, shadow all ones, fim_quadro = 0).
